// File: rtl/rob_queue.sv
// Reorder-buffer queue: circular entry store with dispatch, writeback, commit and flush.
// Define ROB_QUEUE_BYPASS_EN to forward same-cycle writebacks to the operand lookup ports.
module rob_queue #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64,
  parameter int RES_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [DATA_W-1:0] alloc_data,
  output logic [ADDR_W-1:0] alloc_tag,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_tag,
  input  logic [RES_W-1:0]  wb_result,
  input  logic [ADDR_W-1:0] rd0_tag,
  output logic              rd0_done,
  output logic [RES_W-1:0]  rd0_result,
  input  logic [ADDR_W-1:0] rd1_tag,
  output logic              rd1_done,
  output logic [RES_W-1:0]  rd1_result,
  output logic              cm_valid,
  input  logic              cm_ready,
  output logic [DATA_W-1:0] cm_data,
  output logic [RES_W-1:0]  cm_result,
  output logic [ADDR_W-1:0] cm_tag,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_tag,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]   head_q, head_d;
  logic [ADDR_W:0]   tail_q, tail_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [DATA_W-1:0] pay_q [DEPTH];
  logic [RES_W-1:0]  res_q [DEPTH];

  logic [ADDR_W-1:0] h_idx, t_idx, fl_off;
  logic              alloc_fire, cm_fire, wb_hit, fl_hit;
  logic [DEPTH-1:0]  squash;

  assign h_idx = head_q[ADDR_W-1:0];
  assign t_idx = tail_q[ADDR_W-1:0];

  assign count = tail_q - head_q;
  assign empty = (head_q == tail_q);
  assign full  = (h_idx == t_idx) & (head_q[ADDR_W] != tail_q[ADDR_W]);

  assign alloc_ready = ~full & ~flush;
  assign alloc_tag   = t_idx;
  assign alloc_fire  = alloc_valid & alloc_ready;

  assign cm_valid  = ~empty & valid_q[h_idx] & done_q[h_idx];
  assign cm_data   = pay_q[h_idx];
  assign cm_result = res_q[h_idx];
  assign cm_tag    = h_idx;
  assign cm_fire   = cm_valid & cm_ready;

  assign wb_hit = wb_valid & valid_q[wb_tag];

  // Flush only acts when flush_tag lies within [head, tail).
  assign fl_off = flush_tag - h_idx;
  assign fl_hit = flush & ({1'b0, fl_off} < count);

  for (genvar g = 0; g < DEPTH; g++) begin : g_sq
    logic [ADDR_W-1:0] rel;
    assign rel = ADDR_W'(g) - h_idx;
    assign squash[g] = fl_hit & (rel > fl_off)
                     & ({1'b0, rel} < count);
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    done_d  = done_q;
    if (wb_hit) done_d[wb_tag] = 1'b1;
    if (alloc_fire) begin
      valid_d[t_idx] = 1'b1;
      done_d[t_idx]  = 1'b0;
      tail_d         = tail_q + ONE;
    end
    if (cm_fire) begin
      valid_d[h_idx] = 1'b0;
      head_d         = head_q + ONE;
    end
    if (fl_hit) tail_d = head_q + {1'b0, fl_off} + ONE;
    valid_d = valid_d & ~squash;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) pay_q[t_idx] <= alloc_data;
    if (wb_hit) res_q[wb_tag] <= wb_result;
  end

`ifdef ROB_QUEUE_BYPASS_EN
  logic byp0, byp1;
  assign byp0 = wb_valid & (wb_tag == rd0_tag) & valid_q[rd0_tag];
  assign byp1 = wb_valid & (wb_tag == rd1_tag) & valid_q[rd1_tag];
  assign rd0_done   = (valid_q[rd0_tag] & done_q[rd0_tag]) | byp0;
  assign rd1_done   = (valid_q[rd1_tag] & done_q[rd1_tag]) | byp1;
  assign rd0_result = byp0 ? wb_result : res_q[rd0_tag];
  assign rd1_result = byp1 ? wb_result : res_q[rd1_tag];
`else
  assign rd0_done   = valid_q[rd0_tag] & done_q[rd0_tag];
  assign rd1_done   = valid_q[rd1_tag] & done_q[rd1_tag];
  assign rd0_result = res_q[rd0_tag];
  assign rd1_result = res_q[rd1_tag];
`endif

endmodule
